// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, 8N1 framing.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx #(
    parameter int unsigned CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err
);

    localparam logic [15:0] HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic        sync1_q;
    logic        sync2_q;
    logic        rx;
    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic [7:0]  shreg_q;
    logic [7:0]  shreg_d;
    logic [7:0]  data_q;
    logic [7:0]  data_d;
    logic        dv_q;
    logic        dv_d;
    logic        fe_q;
    logic        fe_d;
    logic        perr_q;
    logic        perr_d;
    logic        arm_q;
    logic        arm_d;
    logic        half_done;
    logic        bit_done;

    assign rx        = sync2_q;
    assign half_done = (cnt_q == HALF_M1);
    assign bit_done  = (cnt_q == FULL_M1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        perr_d  = perr_q;
        arm_d   = arm_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d  = 16'd0;
                idx_d  = 3'd0;
                perr_d = 1'b0;
                // a start is only accepted once the line has been seen high
                if (rx) begin
                    arm_d = 1'b1;
                end else if (arm_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (half_done) begin
                    cnt_d   = 16'd0;
                    state_d = rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d          = 16'd0;
                    shreg_d[idx_q] = rx;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d   = 16'd0;
                    perr_d  = rx ^ (^shreg_q);
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // leave at mid-stop so a back-to-back start is not missed
                if (bit_done) begin
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
                    arm_d   = rx;
                    if (rx && !perr_q) begin
                        data_d = shreg_q;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            perr_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            sync1_q <= serial;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
            perr_q  <= perr_d;
            arm_q   <= arm_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;

endmodule
